branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 122 ++++++++++++
 tb/tb_branch_predictor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// branch_predictor: direct-mapped 2-bit counter BTB beside fetch, trained by execute.
// Optional BPU_FWD_EN: same-cycle forwarding of an update into a same-index prediction.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pred_pc,
  output logic        pred_take,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_take,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_take,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  logic             valid_tbl [ENTRIES];
  logic [TAG_W-1:0] tag_tbl   [ENTRIES];
  logic [1:0]       ctr_tbl   [ENTRIES];
  logic [31:0]      tgt_tbl   [ENTRIES];

  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [TAG_W-1:0] pred_tag, upd_tag;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign pred_tag = pred_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  logic             upd_hit;
  logic             nxt_wr;
  logic             nxt_valid;
  logic [TAG_W-1:0] nxt_tag;
  logic [1:0]       nxt_ctr;
  logic [31:0]      nxt_tgt;

  assign upd_hit = valid_tbl[upd_idx] && (tag_tbl[upd_idx] == upd_tag);

  // Entry contents the pending update would leave behind at its index.
  always_comb begin
    nxt_wr    = 1'b0;
    nxt_valid = valid_tbl[upd_idx];
    nxt_tag   = tag_tbl[upd_idx];
    nxt_ctr   = ctr_tbl[upd_idx];
    nxt_tgt   = tgt_tbl[upd_idx];
    if (upd_hit) begin
      nxt_wr = 1'b1;
      if (upd_take) begin
        if (ctr_tbl[upd_idx] != 2'b11) nxt_ctr = ctr_tbl[upd_idx] + 2'd1;
        nxt_tgt = upd_target;
      end else if (ctr_tbl[upd_idx] != 2'b00) begin
        nxt_ctr = ctr_tbl[upd_idx] - 2'd1;
      end
    end else if (upd_take) begin
      nxt_wr    = 1'b1;
      nxt_valid = 1'b1;
      nxt_tag   = upd_tag;
      nxt_ctr   = 2'b10;
      nxt_tgt   = upd_target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_tbl[i] <= 1'b0;
        tag_tbl[i]   <= '0;
        ctr_tbl[i]   <= 2'b01;
        tgt_tbl[i]   <= '0;
      end
    end else if (upd_en && nxt_wr) begin
      valid_tbl[upd_idx] <= nxt_valid;
      tag_tbl[upd_idx]   <= nxt_tag;
      ctr_tbl[upd_idx]   <= nxt_ctr;
      tgt_tbl[upd_idx]   <= nxt_tgt;
    end
  end

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_ctr;
  logic [31:0]      rd_tgt;

  always_comb begin
    rd_valid = valid_tbl[pred_idx];
    rd_tag   = tag_tbl[pred_idx];
    rd_ctr   = ctr_tbl[pred_idx];
    rd_tgt   = tgt_tbl[pred_idx];
`ifdef BPU_FWD_EN
    if (upd_en && (upd_idx == pred_idx)) begin
      rd_valid = nxt_valid;
      rd_tag   = nxt_tag;
      rd_ctr   = nxt_ctr;
      rd_tgt   = nxt_tgt;
    end
`endif
  end

  assign pred_take   = rd_valid && (rd_tag == pred_tag) && rd_ctr[1];
  assign pred_target = rd_tgt;

  assign mispredict = upd_en && ((upd_take != upd_pred_take) ||
                      (upd_take && upd_pred_take && (upd_target != upd_pred_target)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mispred_cnt <= '0;
    end else if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
      mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// tb_branch_predictor: randomized and directed checks against a table-of-entries model.
module tb_branch_predictor;

  logic        clk;
  logic        resetn;
  logic [31:0] pred_pc;
  logic        pred_take;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_take;
  logic [31:0] upd_target;
  logic        upd_pred_take;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] mispred_cnt;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.IDX_W(6), .TAG_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .pred_pc(pred_pc), .pred_take(pred_take), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_take(upd_take), .upd_target(upd_target),
    .upd_pred_take(upd_pred_take), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int unsigned tag;
    int          ctr;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m [64];
  logic [31:0] m_cnt;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc >> 2) & 32'h3F;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> 8) & 32'hFF;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m[i].v = 0; m[i].tag = 0; m[i].ctr = 1; m[i].tgt = '0;
    end
    m_cnt = '0;
  endfunction

  function automatic ent_t next_ent(ent_t e, int unsigned tg, logic tk, logic [31:0] t);
    ent_t r = e;
    if (e.v && e.tag == tg) begin
      if (tk) begin
        r.ctr = (e.ctr < 3) ? e.ctr + 1 : 3;
        r.tgt = t;
      end else begin
        r.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
      end
    end else if (tk) begin
      r.v = 1; r.tag = tg; r.tgt = t; r.ctr = 2;
    end
    return r;
  endfunction

  // Entry the prediction port should observe given the currently driven inputs.
  function automatic ent_t seen_ent();
    ent_t e = m[idx_of(pred_pc)];
`ifdef BPU_FWD_EN
    if (upd_en && idx_of(upd_pc) == idx_of(pred_pc))
      e = next_ent(e, tag_of(upd_pc), upd_take, upd_target);
`endif
    return e;
  endfunction

  function automatic logic exp_take();
    ent_t e = seen_ent();
    return e.v && (e.tag == tag_of(pred_pc)) && (e.ctr >= 2);
  endfunction

  function automatic logic [31:0] exp_target();
    ent_t e = seen_ent();
    return e.tgt;
  endfunction

  function automatic logic exp_mis();
    return upd_en && ((upd_take != upd_pred_take) ||
           (upd_take && upd_pred_take && (upd_target != upd_pred_target)));
  endfunction

  task automatic apply(input logic en, input logic [31:0] upc, input logic tk,
                       input logic [31:0] utgt, input logic ptk, input logic [31:0] ptgt,
                       input logic [31:0] ppc);
    @(negedge clk);
    upd_en = en; upd_pc = upc; upd_take = tk; upd_target = utgt;
    upd_pred_take = ptk; upd_pred_target = ptgt; pred_pc = ppc;
    #1;
  endtask

  // Clock edge: advance the model alongside the DUT, then drop the strobe.
  task automatic commit();
    logic mis;
    mis = exp_mis();
    @(posedge clk);
    if (upd_en) m[idx_of(upd_pc)] = next_ent(m[idx_of(upd_pc)], tag_of(upd_pc), upd_take, upd_target);
    if (mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    #1;
    upd_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      pred_pc = $urandom;
      #1;
      checks++;
      if (pred_take !== 1'b0 || pred_target !== 32'h0 || mispred_cnt !== 32'h0) begin
        errors++;
        $display("FAIL reset pc=%h take=%b tgt=%h cnt=%0d, required 0/0/0",
                 pred_pc, pred_take, pred_target, mispred_cnt);
      end
    end
  endtask

  task automatic test_allocate();
    logic [31:0] pcs [3];
    pcs[0] = 32'h8000_1000; pcs[1] = 32'h8010_1000; pcs[2] = 32'h8000_1100;
    apply(1, 32'h8000_1000, 1, 32'h8000_2000, 0, 32'h0, 32'h8000_1000);
    commit();
    for (int i = 0; i < 3; i++) begin
      apply(0, 32'h0, 0, 32'h0, 0, 32'h0, pcs[i]);
      checks++;
      if (pred_take !== exp_take() || (exp_take() && pred_target !== exp_target())) begin
        errors++;
        $display("FAIL allocate pc=%h take=%b tgt=%h, required %b/%h",
                 pcs[i], pred_take, pred_target, exp_take(), exp_target());
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      apply(1, 32'h8000_1000, (i >= 4), 32'h8000_2000, 0, 32'h0, 32'h8000_1000);
      checks++;
      if (pred_take !== exp_take()) begin
        errors++;
        $display("FAIL saturation step=%0d take=%b, required %b", i, pred_take, exp_take());
      end
      commit();
    end
    apply(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h8000_1000);
    checks++;
    if (pred_take !== 1'b1 || pred_target !== 32'h8000_2000) begin
      errors++;
      $display("FAIL saturation_restore take=%b tgt=%h, required 1/80002000", pred_take, pred_target);
    end
  endtask

  task automatic test_mispredict();
    logic [31:0] base;
    logic        exp_pulse [3];
    exp_pulse[0] = 1; exp_pulse[1] = 1; exp_pulse[2] = 0;
    base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       apply(1, 32'h0000_0204, 1, 32'h0000_3000, 0, 32'h0000_0000, 32'h0);
        1:       apply(1, 32'h0000_0204, 1, 32'h0000_3000, 1, 32'h0000_3004, 32'h0);
        default: apply(1, 32'h0000_0208, 0, 32'h0000_3000, 0, 32'h0000_0000, 32'h0);
      endcase
      checks++;
      if (mispredict !== exp_pulse[i]) begin
        errors++;
        $display("FAIL mispredict_pulse n=%0d got=%b, required %b", i, mispredict, exp_pulse[i]);
      end
      commit();
    end
    checks++;
    if (mispred_cnt !== base + 32'd2) begin
      errors++;
      $display("FAIL mispred_cnt got=%0d, required %0d", mispred_cnt, base + 32'd2);
    end
  endtask

  task automatic test_collision();
    apply(1, 32'h0000_0A40, 1, 32'h0000_5000, 0, 32'h0, 32'h0000_0A40);
    checks++;
`ifdef BPU_FWD_EN
    if (pred_take !== 1'b1) begin
`else
    if (pred_take !== 1'b0) begin
`endif
      errors++;
      $display("FAIL collision take=%b, required %b", pred_take, exp_take());
    end
    commit();
  endtask

  task automatic test_random();
    logic [31:0] tgts [4];
    tgts[0] = 32'h1000_0000; tgts[1] = 32'h2000_0040; tgts[2] = 32'h3000_0080; tgts[3] = 32'hBFC0_0000;
    for (int n = 0; n < 300; n++) begin
      apply($urandom_range(0, 1),
            {16'h0, 8'h20 + 8'($urandom_range(0, 1)), 6'($urandom_range(1, 3)), 2'($urandom_range(0, 3))},
            $urandom_range(0, 1), tgts[$urandom_range(0, 3)],
            $urandom_range(0, 1), tgts[$urandom_range(0, 3)],
            {16'h0, 8'h20 + 8'($urandom_range(0, 1)), 6'($urandom_range(1, 3)), 2'($urandom_range(0, 3))});
      checks++;
      if (pred_take !== exp_take() || pred_target !== exp_target() || mispredict !== exp_mis()) begin
        errors++;
        $display("FAIL random n=%0d take=%b tgt=%h mis=%b, required %b/%h/%b", n,
                 pred_take, pred_target, mispredict, exp_take(), exp_target(), exp_mis());
      end
      commit();
      checks++;
      if (mispred_cnt !== m_cnt) begin
        errors++;
        $display("FAIL random_cnt n=%0d got=%0d, required %0d", n, mispred_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 32'h8000_1000, 1, 32'h8000_2000, 0, 32'h0, 32'h8000_1000);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pred_take !== 1'b0 || pred_target !== 32'h0 || mispred_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid take=%b tgt=%h cnt=%0d, required 0/0/0", pred_take, pred_target, mispred_cnt);
    end
    @(posedge clk); #1;
    upd_en = 1'b0;
    checks++;
    if (pred_take !== 1'b0 || pred_target !== 32'h0 || mispred_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold take=%b tgt=%h cnt=%0d, required 0/0/0", pred_take, pred_target, mispred_cnt);
    end
    @(negedge clk) resetn = 1'b1;
    apply(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h8000_1000);
    checks++;
    if (pred_take !== 1'b0 || pred_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_after take=%b tgt=%h, required 0/0", pred_take, pred_target);
    end
  endtask

  initial begin
    resetn = 1'b0; upd_en = 1'b0; upd_pc = '0; upd_take = 1'b0; upd_target = '0;
    upd_pred_take = 1'b0; upd_pred_target = '0; pred_pc = '0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk) resetn = 1'b1;
    test_allocate();
    test_saturation();
    test_mispredict();
    test_collision();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
